decode_buffer: RTL and testbench



---
 rtl/decode_buffer.sv | 157 +++++++++++++++
 tb/tb_decode_buffer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_buffer.sv
// -----------------------------------------------------------------------------
// decode_buffer
//
// Instruction queue and field decoder between fetch and decode of the
// pipelined MIPS core. It absorbs fetch bursts while decode is stalled,
// discards everything on a taken branch/jump (flush), and presents the head
// instruction already split into its fields.
//
// Optional feature macro: DECODE_BUFFER_BYPASS_EN
//   defined   : an offer arriving at an empty buffer is shown on the head
//               outputs in the same cycle (zero-latency bypass).
//   undefined : no combinational path from the _F inputs to the _D outputs.
//
// Parameters
//   DEPTH  queue entries (power of two, >= 2)
//   WIDTH  instruction / PC width (field positions assume 32)
//
// Ports
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   instruction_F, pc_plus_four_F fetched entry
//   valid_F / ready_F             fetch handshake
//   flush                         discard held and incoming entries
//   stall_D                       decode holds the head
//   valid_D, instruction_D, pc_plus_four_D   head entry
//   opcode, funct, reg_rs_id, reg_rt_id, reg_rd_id, shamt  instruction fields
//   sign_immediate, unsign_immediate          extended instr[15:0]
//   jump_address, branch_address              computed targets
//   count                         occupancy
// -----------------------------------------------------------------------------
module decode_buffer #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           instruction_F,
   input  logic [WIDTH-1:0]           pc_plus_four_F,
   input  logic                       valid_F,
   output logic                       ready_F,
   input  logic                       flush,
   input  logic                       stall_D,
   output logic                       valid_D,
   output logic [WIDTH-1:0]           instruction_D,
   output logic [WIDTH-1:0]           pc_plus_four_D,
   output logic [5:0]                 opcode,
   output logic [5:0]                 funct,
   output logic [4:0]                 reg_rs_id,
   output logic [4:0]                 reg_rt_id,
   output logic [4:0]                 reg_rd_id,
   output logic [4:0]                 shamt,
   output logic [WIDTH-1:0]           sign_immediate,
   output logic [WIDTH-1:0]           unsign_immediate,
   output logic [WIDTH-1:0]           jump_address,
   output logic [WIDTH-1:0]           branch_address,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   // Storage is never cleared; only pointers and occupancy are reset.
   logic [WIDTH-1:0] mem_instr_q [DEPTH];
   logic [WIDTH-1:0] mem_pc_q    [DEPTH];

   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q,  count_d;

   logic             empty;
   logic             head_valid;
   logic [WIDTH-1:0] head_instr;
   logic [WIDTH-1:0] head_pc;
   logic             bypass_take;
   logic             push;
   logic             pop;

   assign empty   = (count_q == '0);
   assign ready_F = !reset && (count_q < DEPTH_C);

   // Head selection: stored head, or (with bypass) the live fetch offer when empty.
   always_comb begin
      head_valid  = !empty;
      head_instr  = empty ? '0 : mem_instr_q[rd_ptr_q];
      head_pc     = empty ? '0 : mem_pc_q[rd_ptr_q];
      bypass_take = 1'b0;
`ifdef DECODE_BUFFER_BYPASS_EN
      if (empty && valid_F && !flush && !reset) begin
         head_valid  = 1'b1;
         head_instr  = instruction_F;
         head_pc     = pc_plus_four_F;
         // Consumed straight through when decode is free; otherwise it is
         // written below and becomes the stored head next cycle.
         bypass_take = !stall_D;
      end
`endif
   end

   // A pop only ever removes a stored entry; bypassed entries never enter storage.
   assign push = valid_F && ready_F && !flush && !bypass_take;
   assign pop  = !empty && !stall_D;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push && !reset) begin
         mem_instr_q[wr_ptr_q] <= instruction_F;
         mem_pc_q[wr_ptr_q]    <= pc_plus_four_F;
      end
   end

   // Field decode, purely combinational from the head entry.
   assign valid_D          = head_valid;
   assign instruction_D    = head_instr;
   assign pc_plus_four_D   = head_pc;
   assign count            = count_q;
   assign opcode           = head_instr[31:26];
   assign reg_rs_id        = head_instr[25:21];
   assign reg_rt_id        = head_instr[20:16];
   assign reg_rd_id        = head_instr[15:11];
   assign shamt            = head_instr[10:6];
   assign funct            = head_instr[5:0];
   assign sign_immediate   = {{(WIDTH-16){head_instr[15]}}, head_instr[15:0]};
   assign unsign_immediate = {{(WIDTH-16){1'b0}}, head_instr[15:0]};
   assign jump_address     = {head_pc[WIDTH-1:WIDTH-4], head_instr[25:0], 2'b00};
   assign branch_address   = head_pc + {sign_immediate[WIDTH-3:0], 2'b00};

endmodule

// File: tb/tb_decode_buffer.sv
module tb_decode_buffer;

   localparam int DEPTH = 4;
   localparam int WIDTH = 32;
`ifdef DECODE_BUFFER_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic              clock;
   logic              reset;
   logic [WIDTH-1:0]  instruction_F;
   logic [WIDTH-1:0]  pc_plus_four_F;
   logic              valid_F;
   logic              ready_F;
   logic              flush;
   logic              stall_D;
   logic              valid_D;
   logic [WIDTH-1:0]  instruction_D;
   logic [WIDTH-1:0]  pc_plus_four_D;
   logic [5:0]        opcode;
   logic [5:0]        funct;
   logic [4:0]        reg_rs_id;
   logic [4:0]        reg_rt_id;
   logic [4:0]        reg_rd_id;
   logic [4:0]        shamt;
   logic [WIDTH-1:0]  sign_immediate;
   logic [WIDTH-1:0]  unsign_immediate;
   logic [WIDTH-1:0]  jump_address;
   logic [WIDTH-1:0]  branch_address;
   logic [2:0]        count;

   decode_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clock(clock), .reset(reset),
      .instruction_F(instruction_F), .pc_plus_four_F(pc_plus_four_F),
      .valid_F(valid_F), .ready_F(ready_F), .flush(flush), .stall_D(stall_D),
      .valid_D(valid_D), .instruction_D(instruction_D), .pc_plus_four_D(pc_plus_four_D),
      .opcode(opcode), .funct(funct), .reg_rs_id(reg_rs_id), .reg_rt_id(reg_rt_id),
      .reg_rd_id(reg_rd_id), .shamt(shamt), .sign_immediate(sign_immediate),
      .unsign_immediate(unsign_immediate), .jump_address(jump_address),
      .branch_address(branch_address), .count(count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: a plain FIFO of (instr, pc) ----------
   logic [31:0] qi[$];
   logic [31:0] qp[$];
   bit          model_ok = 1'b0;

   // Expected head given the queue and the live inputs.
   function automatic void model_head(output bit v, output logic [31:0] hi, output logic [31:0] hp);
      v = 1'b0; hi = 32'h0; hp = 32'h0;
      if (qi.size() > 0) begin
         v = 1'b1; hi = qi[0]; hp = qp[0];
      end else if (BYP && valid_F && !flush && !reset) begin
         v = 1'b1; hi = instruction_F; hp = pc_plus_four_F;
      end
   endfunction

   always @(posedge clock) begin
      bit          v;
      logic [31:0] hi, hp;
      bit          rdy;
      model_head(v, hi, hp);
      rdy = !reset && (qi.size() < DEPTH);
      if (reset) begin
         qi.delete(); qp.delete(); model_ok = 1'b1;
      end else if (flush) begin
         qi.delete(); qp.delete();
      end else if (qi.size() == 0 && BYP && valid_F) begin
         // bypassed offer: consumed if decode free, else stored
         if (stall_D) begin qi.push_back(instruction_F); qp.push_back(pc_plus_four_F); end
      end else begin
         if (v && !stall_D) begin void'(qi.pop_front()); void'(qp.pop_front()); end
         if (valid_F && rdy) begin qi.push_back(instruction_F); qp.push_back(pc_plus_four_F); end
      end
   end

   // Compare process: every cycle, away from the active edge.
   always @(negedge clock) begin
      bit          v;
      logic [31:0] hi, hp, simm;
      if (model_ok) begin
         model_head(v, hi, hp);
         simm = (hi & 32'h0000FFFF) | (hi[15] ? 32'hFFFF0000 : 32'h0);
         chk("ready_F", 32'(ready_F), 32'(!reset && qi.size() < DEPTH));
         chk("count", 32'(count), qi.size());
         chk("valid_D", 32'(valid_D), 32'(v));
         chk("instruction_D", instruction_D, hi);
         chk("pc_plus_four_D", pc_plus_four_D, hp);
         chk("opcode", 32'(opcode), hi / 32'd67108864);
         chk("rs", 32'(reg_rs_id), (hi / 32'd2097152) % 32);
         chk("rt", 32'(reg_rt_id), (hi / 32'd65536) % 32);
         chk("rd", 32'(reg_rd_id), (hi / 32'd2048) % 32);
         chk("shamt", 32'(shamt), (hi / 32'd64) % 32);
         chk("funct", 32'(funct), hi % 64);
         chk("sign_immediate", sign_immediate, simm);
         chk("unsign_immediate", unsign_immediate, hi % 65536);
         chk("jump_address", jump_address, (hp & 32'hF0000000) + (hi % 32'h04000000) * 4);
         chk("branch_address", branch_address, hp + simm * 4);
      end
   end

   // ---------------- stimulus --------------------------------------------
   task automatic drive(input bit vf, input logic [31:0] ins, input logic [31:0] pc,
                        input bit st, input bit fl);
      valid_F = vf; instruction_F = ins; pc_plus_four_F = pc; stall_D = st; flush = fl;
   endtask

   task automatic tick();
      @(posedge clock); #1;
   endtask

   task automatic at_neg();
      @(negedge clock); #1;
   endtask

   logic [31:0] fill_v [4];

   initial begin
      fill_v[0] = 32'h20080005; fill_v[1] = 32'h20090007;
      fill_v[2] = 32'h01095020; fill_v[3] = 32'h08000010;

      // reset held 2 cycles while fetch offers
      reset = 1'b1;
      drive(1'b1, 32'h12345678, 32'h00400004, 1'b0, 1'b0);
      tick();
      at_neg();
      chk("rst_ready", 32'(ready_F), 32'h0);
      chk("rst_valid", 32'(valid_D), 32'h0);
      chk("rst_count", 32'(count), 32'h0);
      tick();
      reset = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      at_neg();
      chk("post_rst_ready", 32'(ready_F), 32'h1);
      chk("empty_instr", instruction_D, 32'h0);
      tick();

      // bypass vs. not, from empty
      drive(1'b1, 32'h24020001, 32'h00400004, 1'b0, 1'b0);
      at_neg();
      chk("byp_valid_same", 32'(valid_D), BYP ? 32'h1 : 32'h0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      at_neg();
      chk("byp_valid_next", 32'(valid_D), BYP ? 32'h0 : 32'h1);
      chk("byp_instr_next", instruction_D, BYP ? 32'h0 : 32'h24020001);
      chk("byp_count", 32'(count), BYP ? 32'h0 : 32'h1);
      tick();

      // fill under stall, offer a fifth, then drain in order
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, fill_v[i], 32'h00400000 + 32'(4 * (i + 1)), 1'b1, 1'b0);
         tick();
      end
      drive(1'b1, 32'hDEADBEEF, 32'h00400014, 1'b1, 1'b0);
      at_neg();
      chk("full_count", 32'(count), 32'd4);
      chk("full_ready", 32'(ready_F), 32'h0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         at_neg();
         chk("drain_instr", instruction_D, fill_v[i]);
         tick();
      end
      at_neg();
      chk("drained_valid", 32'(valid_D), 32'h0);

      // decode fields: branch
      drive(1'b1, 32'h1109FFFE, 32'h00400014, 1'b1, 1'b0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      at_neg();
      chk("dec_opcode", 32'(opcode), 32'd4);
      chk("dec_rs", 32'(reg_rs_id), 32'd8);
      chk("dec_rt", 32'(reg_rt_id), 32'd9);
      chk("dec_simm", sign_immediate, 32'hFFFFFFFE);
      chk("dec_uimm", unsign_immediate, 32'h0000FFFE);
      chk("dec_branch", branch_address, 32'h0040000C);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      tick();
      // decode fields: jump
      drive(1'b1, 32'h0810000A, 32'h00400020, 1'b1, 1'b0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      at_neg();
      chk("dec_jump", jump_address, 32'h00400028);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      tick();

      // flush with three held entries and a concurrent offer
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h30000000 + 32'(i), 32'h00500000 + 32'(4 * i), 1'b1, 1'b0);
         tick();
      end
      drive(1'b1, 32'h00000020, 32'h00500010, 1'b1, 1'b1);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      at_neg();
      chk("flush_valid", 32'(valid_D), 32'h0);
      chk("flush_count", 32'(count), 32'h0);
      drive(1'b1, 32'h2010ABCD, 32'h00600004, 1'b1, 1'b0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      at_neg();
      chk("post_flush_instr", instruction_D, 32'h2010ABCD);
      chk("post_flush_count", 32'(count), 32'h1);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      tick();

      // continuous push/pop across pointer wrap
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 32'h00001000 + 32'(i), 32'h00700000 + 32'(4 * i), 1'b0, 1'b0);
         at_neg();
         if (i >= 1) chk("wrap_count", 32'(count), BYP ? 32'h0 : 32'h1);
         tick();
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      tick();

      // randomized traffic in phases of varying stall pressure
      for (int i = 0; i < 3000; i++) begin
         int stall_pct;
         stall_pct = ((i / 200) % 3 == 0) ? 10 : (((i / 200) % 3 == 1) ? 70 : 35);
         drive(($urandom % 4) != 0, $urandom, $urandom,
               ($urandom % 100) < 32'(stall_pct), ($urandom % 40) == 0);
         tick();
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      tick();
      at_neg();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
